// File: rtl/aes128_inv_key_sched.sv
// aes128_inv_key_sched: decryption-side AES-128 round-key generator.
// Expands the cipher key forward to round key 10, then steps backwards one
// round key per request (10 down to 0) for the inverse-cipher datapath.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   key_load, key_in     load pulse and 128-bit cipher key (byte 0 = [127:120])
//   rk_next, rk_rewind   step back one round key / reload saved round key 10
//   key_ready            round key 10 has been reached since the last load
//   rk_valid             rk_out holds a valid round key
//   rk_round, rk_out     index and value of the current round key
// Only NR = 10 (AES-128) is a legal parameter value.
module aes128_inv_key_sched #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_load,
    input  logic [127:0] key_in,
    input  logic         rk_next,
    input  logic         rk_rewind,
    output logic         key_ready,
    output logic         rk_valid,
    output logic [3:0]   rk_round,
    output logic [127:0] rk_out
);
    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;
    // First listed byte is S(0x00) and lands at index 255, hence the ~x lookup.
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    // Rcon indexed directly by round number; entries 0 and 11..15 are unused.
    localparam logic [15:0][7:0] RCON = {40'h0, 80'h361b8040201008040201, 8'h00};
    state_t         state_q, state_d;
    logic [127:0]   rk_q, rk_d, save_q, save_d;
    logic [3:0]     round_q, round_d, rc_idx;
    logic           ready_q, ready_d;
    logic [31:0]    w0, w1, w2, w3, n1, n2, n3, sb_in, sub, f0;
    logic [127:0]   fwd, rev;
    assign {w0, w1, w2, w3} = rk_q;
    assign n3 = w3 ^ w2;
    assign n2 = w2 ^ w1;
    assign n1 = w1 ^ w0;
    // One shared S-box bank: forward uses rotated w3, reverse uses rotated
    // n3 (the recovered previous w3). Rcon likewise is r+1 forward, r reverse.
    assign sb_in  = (state_q == EXPAND) ? {w3[23:0], w3[31:24]} : {n3[23:0], n3[31:24]};
    assign rc_idx = (state_q == EXPAND) ? round_q + 4'd1 : round_q;
    assign sub = {SBOX[~sb_in[31:24]] ^ RCON[rc_idx], SBOX[~sb_in[23:16]],
                  SBOX[~sb_in[15:8]], SBOX[~sb_in[7:0]]};
    // Both directions produce their new w0 as w0 ^ sub.
    assign f0  = w0 ^ sub;
    assign fwd = {f0, f0 ^ w1, f0 ^ w1 ^ w2, f0 ^ w1 ^ w2 ^ w3};
    assign rev = {f0, n1, n2, n3};
    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        save_d  = save_q;
        round_d = round_q;
        ready_d = ready_q;
        if (key_load) begin
            state_d = EXPAND;
            rk_d    = key_in;
            round_d = 4'd0;
            ready_d = 1'b0;
        end else if (state_q == EXPAND) begin
            rk_d    = fwd;
            round_d = round_q + 4'd1;
            if (round_q == 4'(NR - 1)) begin
                save_d  = fwd;
                state_d = READY;
                ready_d = 1'b1;
            end
        end else if (state_q == READY && rk_rewind) begin
            rk_d    = save_q;
            round_d = 4'(NR);
        end else if (state_q == READY && rk_next && round_q != 4'd0) begin
            rk_d    = rev;
            round_d = round_q - 4'd1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rk_q    <= '0;
            save_q  <= '0;
            round_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            save_q  <= save_d;
            round_q <= round_d;
            ready_q <= ready_d;
        end
    end
    // ready_q is set exactly when READY is entered and cleared on leaving it,
    // so it serves as both the key_ready flag and the registered rk_valid.
    assign key_ready = ready_q;
    assign rk_valid  = ready_q;
    assign rk_round  = round_q;
    assign rk_out    = rk_q;
endmodule

// File: tb/tb_aes128_inv_key_sched.sv
// tb_aes128_inv_key_sched: directed bench with a table-level AES key-expansion model.
module tb_aes128_inv_key_sched;
    localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    logic         clk = 1'b0, rst_n = 1'b1, key_load = 1'b0, rk_next = 1'b0, rk_rewind = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_ready, rk_valid;
    logic [3:0]   rk_round;
    logic [127:0] rk_out;
    int           n_tests = 0, n_fail = 0;
    bit           chk_en = 1'b0;
    logic [7:0]   sb [256];
    logic [127:0] m_key = '0;
    int           m_st = 0, m_round = 0;

    always #5 clk = ~clk;

    aes128_inv_key_sched dut (
        .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
        .rk_next(rk_next), .rk_rewind(rk_rewind), .key_ready(key_ready),
        .rk_valid(rk_valid), .rk_round(rk_round), .rk_out(rk_out)
    );

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    // Full forward key expansion; returns round key r.
    function automatic logic [127:0] rk_of(logic [127:0] k, int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: which key is loaded, which phase we are in, which round is shown.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st <= 0;
            m_round <= 0;
            m_key <= '0;
        end else if (key_load) begin
            m_key <= key_in;
            m_st <= 1;
            m_round <= 0;
        end else if (m_st == 1) begin
            m_round <= m_round + 1;
            if (m_round == 9) m_st <= 2;
        end else if (m_st == 2 && rk_rewind) begin
            m_round <= 10;
        end else if (m_st == 2 && rk_next && m_round > 0) begin
            m_round <= m_round - 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model rk_out", rk_out, m_st == 0 ? 128'h0 : rk_of(m_key, m_round));
            check("model rk_round", 128'(rk_round), 128'(m_round));
            check("model key_ready", 128'(key_ready), 128'(m_st == 2));
            check("model rk_valid", 128'(rk_valid), 128'(m_st == 2));
        end
    end

    // Drive one cycle of inputs right after a falling edge, return at the next one.
    task automatic cyc(logic ld, logic [127:0] k, logic nx, logic rw);
        key_load = ld; key_in = k; rk_next = nx; rk_rewind = rw;
        @(negedge clk);
        key_load = 1'b0; key_in = '0; rk_next = 1'b0; rk_rewind = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] b;
        for (int x = 0; x < 256; x++) begin
            b = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
        #1 rst_n = 1'b0;
        #2 chk_en = 1'b1;
        check("reset rk_out", rk_out, 128'h0);
        check("reset ready", 128'(key_ready), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        check("model pin r1", rk_of(K1, 1), 128'ha0fafe1788542cb123a339392a6c7605);
        check("model pin r10", rk_of(K1, 10), K1R10);
        // Load and forward expansion
        cyc(1'b1, K1, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            cyc(1'b0, '0, 1'b0, 1'b0);
            check("ready low during expand", 128'(key_ready), 128'h0);
        end
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("load ready", 128'(key_ready), 128'h1);
        check("load round", 128'(rk_round), 128'd10);
        check("load rk10", rk_out, K1R10);
        // Reverse walk
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("rev rk9", rk_out, 128'hac7766f319fadc2128d12941575c006e);
        check("rev round9", 128'(rk_round), 128'd9);
        repeat (7) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("rev rk1", rk_out, 128'ha0fafe1788542cb123a339392a6c7605);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("rev rk0", rk_out, K1);
        check("rev round0", 128'(rk_round), 128'd0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("no wrap rk", rk_out, K1);
        check("no wrap round", 128'(rk_round), 128'd0);
        // Rewind
        cyc(1'b0, '0, 1'b0, 1'b1);
        check("rewind from 0", rk_out, K1R10);
        repeat (6) cyc(1'b0, '0, 1'b1, 1'b0);
        check("walk to 4", 128'(rk_round), 128'd4);
        cyc(1'b0, '0, 1'b0, 1'b1);
        check("rewind rk", rk_out, K1R10);
        check("rewind round", 128'(rk_round), 128'd10);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b1);
        check("rewind beats next", 128'(rk_round), 128'd10);
        check("rewind beats next rk", rk_out, K1R10);
        // Restart mid-expansion with next/rewind held (both ignored)
        cyc(1'b1, K1, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, '0, 1'b1, 1'b1);
        check("mid expand round", 128'(rk_round), 128'd5);
        cyc(1'b1, '0, 1'b0, 1'b0);
        check("restart round", 128'(rk_round), 128'd0);
        check("restart rk", rk_out, 128'h0);
        repeat (10) cyc(1'b0, '0, 1'b0, 1'b0);
        check("zero key rk10", rk_out, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        check("zero key ready", 128'(key_ready), 128'h1);
        // Asynchronous reset mid-reverse
        repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);
        check("pre-reset round", 128'(rk_round), 128'd6);
        #2 rst_n = 1'b0;
        #1;
        check("async rst rk", rk_out, 128'h0);
        check("async rst round", 128'(rk_round), 128'h0);
        check("async rst valid", 128'(rk_valid), 128'h0);
        check("async rst ready", 128'(key_ready), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
        check("next after reset round", 128'(rk_round), 128'h0);
        check("next after reset valid", 128'(rk_valid), 128'h0);
        // Reload with bounded wait for key_ready
        cyc(1'b1, K1, 1'b0, 1'b0);
        n = 0;
        while (!key_ready && n < 20) begin
            cyc(1'b0, '0, 1'b0, 1'b0);
            n++;
        end
        check("reload ready", 128'(key_ready), 128'h1);
        check("reload latency", 128'(n), 128'd10);
        check("reload rk10", rk_out, K1R10);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/aes128_inv_key_sched.md
Name: aes128_inv_key_sched

Overview:
- Decryption-side round-key generator for the AES-128 core.
- On key load, it first expands the 128-bit cipher key forward to round key 10.
- It then steps backwards one round key per request: 10, 9, … 0, which is the order the inverse-cipher datapath consumes them.
- It keeps its own 128-bit round-key register, a saved copy of round key 10, and a single shared 4-byte S-box bank.

Parameters:
- NR, 10, number of rounds. Only 10 (AES-128) is supported; any other value is illegal.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- key_load  input  1  one-cycle pulse; samples key_in and starts forward expansion
- key_in  input  128  cipher key. Byte 0 is [127:120]; word w0 is [127:96].
- rk_next  input  1  request the previous round key (round r → r-1)
- rk_rewind  input  1  reload the saved round key 10
- key_ready  output  1  high once round key 10 is available; stays high until the next key_load or reset
- rk_valid  output  1  rk_out holds a valid round key
- rk_round  output  4  index of the round key currently on rk_out (0..10)
- rk_out  output  128  current round-key register, same byte order as key_in

Behaviour:
- Async reset (rst_n=0): state=IDLE, rk_out=0, saved key=0, rk_round=0, key_ready=0, rk_valid=0. Reset mid-expansion or mid-reverse aborts immediately.
- FSM states: IDLE, EXPAND, READY.
- Input priority, same edge: key_load > rk_rewind > rk_next. This applies in every state.
- key_load, at edge E0:
  - rk_out ← key_in, rk_round ← 0, state ← EXPAND, key_ready ← 0.
  - Restarts from any state, including mid-EXPAND.
- EXPAND, one forward step per edge E1..E10:
  - Rotated word: {w3[23:0], w3[31:24]}.
  - w0' = w0 ^ SubWord(that rotated word) ^ {Rcon[r+1], 24'h0}.
  - w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'.
  - rk_round increments on each step.
  - On the edge where rk_round becomes 10: saved key ← result, state ← READY, key_ready ← 1.
  - key_ready and rk_valid are therefore first high after edge E10, 10 cycles after the load edge.
- Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36. This is combinational, indexed by round.
- READY + rk_next with rk_round>0, single-cycle reverse step:
  - n3 = w3 ^ w2, n2 = w2 ^ w1, n1 = w1 ^ w0.
  - n0 = w0 ^ SubWord({n3[23:0], n3[31:24]}) ^ {Rcon[r], 24'h0}.
  - rk_out ← {n0, n1, n2, n3}, rk_round decrements.
- READY + rk_next with rk_round=0: ignored. No wrap, and outputs are held.
- READY + rk_rewind: rk_out ← saved key, rk_round ← 10. Takes 1 cycle; legal at any round.
- rk_next or rk_rewind in IDLE or EXPAND: ignored.
- rk_valid = (state==READY), registered. rk_out is otherwise held between requests.
- S-box bank (4 byte lookups) is muxed:
  - EXPAND drives it with rotated w3.
  - READY drives it with rotated n3.
  - One bank only; the lookup table is internal to the block.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
1. Load: key_load with key_in=2b7e151628aed2a6abf7158809cf4f3c → after 10 further edges: key_ready=1, rk_round=10, rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6; key_ready=0 during E1..E9.
2. Reverse walk: 10× rk_next after test 1 →
   - first step: rk_out=ac7766f319fadc2128d12941575c006e, rk_round=9
   - step 9: rk_out=a0fafe1788542cb123a339392a6c7605
   - step 10: rk_out=2b7e151628aed2a6abf7158809cf4f3c, rk_round=0
   - an 11th rk_next leaves everything unchanged.
3. Rewind: at rk_round=4, rk_rewind → next cycle rk_out=d014f9a8…0ca6, rk_round=10. rk_rewind and rk_next together → rewind wins.
4. Restart: key_load mid-EXPAND (at rk_round=5) with key=000…0 → expansion restarts from round 0. Final rk_out=b4ef5bcb3e92e21123e951cf6f8f188e after 10 edges.
5. Reset: rst_n low mid-reverse (rk_round=6), asynchronously between edges → outputs zero immediately, state IDLE. rk_next after release is ignored until the next key_load.
